// File: rtl/i_cache_pkg.sv
// Shared geometry constants and FSM encoding for the direct-mapped instruction cache.
package i_cache_pkg;

    localparam int unsigned INDEX_BITS = 7;
    localparam int unsigned ADDR_LEN   = 32;
    localparam int unsigned INST_LEN   = 32;
    localparam int unsigned TAG_BITS   = ADDR_LEN - INDEX_BITS - 2;

    localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

    typedef enum logic {
        IcIdle = 1'b0,
        IcMiss = 1'b1
    } ic_state_e;

endpackage

// File: rtl/i_cache_mem.sv
// Valid/tag/data storage: combinational read by index, single posedge write port.
module i_cache_mem
    import i_cache_pkg::*;
#(
    parameter int unsigned IndexBits = INDEX_BITS,
    parameter int unsigned TagBits   = TAG_BITS,
    parameter int unsigned DataBits  = INST_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IndexBits-1:0] rd_idx_i,
    output logic                 rd_valid_o,
    output logic [TagBits-1:0]   rd_tag_o,
    output logic [DataBits-1:0]  rd_data_o,
    input  logic                 we_i,
    input  logic [IndexBits-1:0] wr_idx_i,
    input  logic [TagBits-1:0]   wr_tag_i,
    input  logic [DataBits-1:0]  wr_data_i
);

    localparam int unsigned Lines = 1 << IndexBits;

    logic [Lines-1:0]    valid_q;
    logic [TagBits-1:0]  tag_q  [Lines];
    logic [DataBits-1:0] data_q [Lines];

    // Only the valid bits are reset; tag/data contents are don't-care until filled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped instruction cache: one word per line, refills from mem_ctrl on a miss.
module i_cache
    import i_cache_pkg::*;
#(
    parameter int unsigned IndexBits = INDEX_BITS,
    parameter int unsigned AddrLen   = ADDR_LEN,
    parameter int unsigned InstLen   = INST_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump_signal,
    input  logic               if_req,
    input  logic [AddrLen-1:0] if_addr,
    output logic               busy_o,
    output logic               inst_valid_o,
    output logic [InstLen-1:0] inst_o,
    output logic               icache_needed,
    output logic [AddrLen-1:0] icache_addr,
    input  logic               inst_available_i,
    input  logic [InstLen-1:0] inst_i
);

    localparam int unsigned TagBits = AddrLen - IndexBits - 2;

    ic_state_e          state_q, state_d;
    logic [AddrLen-1:0] miss_addr_q, miss_addr_d;
    logic [InstLen-1:0] inst_q, inst_d;
    logic               inst_valid_q, inst_valid_d;

    logic [IndexBits-1:0] req_idx, miss_idx;
    logic [TagBits-1:0]   req_tag, miss_tag;
    logic                 rd_valid;
    logic [TagBits-1:0]   rd_tag;
    logic [InstLen-1:0]   rd_data;
    logic                 fill_we;
    logic                 accept;
    logic                 hit;

    assign req_idx  = if_addr[IndexBits+1:2];
    assign req_tag  = if_addr[AddrLen-1:IndexBits+2];
    assign miss_idx = miss_addr_q[IndexBits+1:2];
    assign miss_tag = miss_addr_q[AddrLen-1:IndexBits+2];

    i_cache_mem #(
        .IndexBits (IndexBits),
        .TagBits   (TagBits),
        .DataBits  (InstLen)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (fill_we),
        .wr_idx_i   (miss_idx),
        .wr_tag_i   (miss_tag),
        .wr_data_i  (inst_i)
    );

    assign accept = if_req && !jump_signal;
    assign hit    = rd_valid && (rd_tag == req_tag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IcIdle;
            miss_addr_q  <= '0;
            inst_q       <= ZERO_WORD;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IcIdle: if (accept && !hit) state_d = IcMiss;
            IcMiss: if (inst_available_i || jump_signal) state_d = IcIdle;
            default: state_d = IcIdle;
        endcase
    end

    always_comb begin
        miss_addr_d  = miss_addr_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        fill_we      = 1'b0;
        unique case (state_q)
            IcIdle: begin
                if (accept) begin
                    if (hit) begin
                        inst_d       = rd_data;
                        inst_valid_d = 1'b1;
                    end else begin
                        miss_addr_d = if_addr;
                    end
                end
            end
            IcMiss: begin
                // A refill that races a redirect is still correct for miss_addr, so keep it.
                if (inst_available_i) begin
                    fill_we = 1'b1;
                    if (!jump_signal) begin
                        inst_d       = inst_i;
                        inst_valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_o        = (state_q != IcIdle);
    assign icache_needed = (state_q == IcMiss);
    assign icache_addr   = miss_addr_q;
    assign inst_o        = inst_q;
    assign inst_valid_o  = inst_valid_q;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], miss_addr_q[1:0]};

endmodule

// File: tb/tb_i_cache.sv
// Directed bench for i_cache: fetch table plus hand-written jump/reset sequences.
module tb_i_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_signal;
    logic        if_req;
    logic [31:0] if_addr;
    logic        busy_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic        icache_needed;
    logic [31:0] icache_addr;
    logic        inst_available_i;
    logic [31:0] inst_i;

    int n_cmp = 0;
    int n_err = 0;

    i_cache dut (
        .clk              (clk),
        .rst              (rst),
        .jump_signal      (jump_signal),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .busy_o           (busy_o),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .icache_needed    (icache_needed),
        .icache_addr      (icache_addr),
        .inst_available_i (inst_available_i),
        .inst_i           (inst_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one fetch; on a miss, return the refill word after lat cycles in MISS.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input bit exp_hit,
                         input int lat);
        if_req  = 1'b1;
        if_addr = a;
        step();
        if_req = 1'b0;
        if (exp_hit) begin
            check("hit_valid", {31'b0, inst_valid_o}, 32'd1);
            check("hit_data", inst_o, d);
            check("hit_needed", {31'b0, icache_needed}, 32'd0);
            check("hit_busy", {31'b0, busy_o}, 32'd0);
        end else begin
            check("miss_needed", {31'b0, icache_needed}, 32'd1);
            check("miss_addr", icache_addr, a);
            check("miss_busy", {31'b0, busy_o}, 32'd1);
            check("miss_novalid", {31'b0, inst_valid_o}, 32'd0);
            for (int i = 1; i < lat; i++) begin
                step();
                check("miss_hold", {31'b0, icache_needed}, 32'd1);
            end
            inst_available_i = 1'b1;
            inst_i           = d;
            step();
            inst_available_i = 1'b0;
            inst_i           = 32'hFFFF_FFFF;
            check("fill_valid", {31'b0, inst_valid_o}, 32'd1);
            check("fill_data", inst_o, d);
            check("fill_needed", {31'b0, icache_needed}, 32'd0);
            check("fill_busy", {31'b0, busy_o}, 32'd0);
        end
        step();
        check("pulse_end", {31'b0, inst_valid_o}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{addr: 32'h0000_0000, data: 32'h0000_0013, hit: 1'b0, lat: 2};
        vecs[1]  = '{addr: 32'h0000_1004, data: 32'h00A0_0093, hit: 1'b0, lat: 4};
        vecs[2]  = '{addr: 32'h0000_1004, data: 32'h00A0_0093, hit: 1'b1, lat: 0};
        vecs[3]  = '{addr: 32'h0000_0004, data: 32'h1111_1111, hit: 1'b0, lat: 1};
        vecs[4]  = '{addr: 32'h0000_0204, data: 32'h2222_2222, hit: 1'b0, lat: 2};
        vecs[5]  = '{addr: 32'h0000_0004, data: 32'h1111_1111, hit: 1'b0, lat: 3};
        vecs[6]  = '{addr: 32'h0000_0004, data: 32'h1111_1111, hit: 1'b1, lat: 0};
        vecs[7]  = '{addr: 32'h0000_0010, data: 32'hAAAA_0010, hit: 1'b0, lat: 1};
        vecs[8]  = '{addr: 32'h0000_0014, data: 32'hAAAA_0014, hit: 1'b0, lat: 2};
        vecs[9]  = '{addr: 32'h0000_0018, data: 32'hAAAA_0018, hit: 1'b0, lat: 1};
        vecs[10] = '{addr: 32'h0000_0000, data: 32'h0000_0013, hit: 1'b1, lat: 0};
        vecs[11] = '{addr: 32'h0000_1004, data: 32'h00A0_0093, hit: 1'b0, lat: 2};

        rst              = 1'b0;
        jump_signal      = 1'b0;
        if_req           = 1'b0;
        if_addr          = '0;
        inst_available_i = 1'b0;
        inst_i           = '0;
        step();
        step();
        check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_needed", {31'b0, icache_needed}, 32'd0);
        check("rst_addr", icache_addr, 32'd0);
        rst = 1'b1;
        step();

        for (int v = 0; v < 12; v++) begin
            fetch(vecs[v].addr, vecs[v].data, vecs[v].hit, vecs[v].lat);
        end

        // Back-to-back hits on consecutive cycles.
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        step();
        check("b2b_v0", {31'b0, inst_valid_o}, 32'd1);
        check("b2b_d0", inst_o, 32'hAAAA_0010);
        if_addr = 32'h0000_0014;
        step();
        check("b2b_v1", {31'b0, inst_valid_o}, 32'd1);
        check("b2b_d1", inst_o, 32'hAAAA_0014);
        if_addr = 32'h0000_0018;
        step();
        check("b2b_v2", {31'b0, inst_valid_o}, 32'd1);
        check("b2b_d2", inst_o, 32'hAAAA_0018);
        if_req = 1'b0;
        step();
        check("b2b_end", {31'b0, inst_valid_o}, 32'd0);
        check("b2b_hold", inst_o, 32'hAAAA_0018);

        // Jump in IDLE suppresses even a hitting request.
        if_req      = 1'b1;
        if_addr     = 32'h0000_0010;
        jump_signal = 1'b1;
        step();
        if_req      = 1'b0;
        jump_signal = 1'b0;
        check("jidle_valid", {31'b0, inst_valid_o}, 32'd0);
        check("jidle_busy", {31'b0, busy_o}, 32'd0);

        // Jump during MISS before refill, then a stray late refill.
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        step();
        if_req = 1'b0;
        check("jmiss_needed", {31'b0, icache_needed}, 32'd1);
        step();
        jump_signal = 1'b1;
        step();
        jump_signal = 1'b0;
        check("jmiss_drop", {31'b0, icache_needed}, 32'd0);
        check("jmiss_novalid", {31'b0, inst_valid_o}, 32'd0);
        check("jmiss_busy", {31'b0, busy_o}, 32'd0);
        inst_available_i = 1'b1;
        inst_i           = 32'hDEAD_BEEF;
        step();
        inst_available_i = 1'b0;
        check("late_novalid", {31'b0, inst_valid_o}, 32'd0);
        check("late_inst", inst_o, 32'hAAAA_0018);
        fetch(32'h0000_0040, 32'h5555_0040, 1'b0, 2);

        // Jump coincident with refill: line filled, no pulse.
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        step();
        if_req = 1'b0;
        check("jfill_needed", {31'b0, icache_needed}, 32'd1);
        jump_signal      = 1'b1;
        inst_available_i = 1'b1;
        inst_i           = 32'h7777_0080;
        step();
        jump_signal      = 1'b0;
        inst_available_i = 1'b0;
        check("jfill_novalid", {31'b0, inst_valid_o}, 32'd0);
        check("jfill_needed0", {31'b0, icache_needed}, 32'd0);
        fetch(32'h0000_0080, 32'h7777_0080, 1'b1, 0);

        // Reset mid-miss abandons the miss and invalidates all lines.
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        step();
        if_req = 1'b0;
        check("rmiss_needed", {31'b0, icache_needed}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rmiss_drop", {31'b0, icache_needed}, 32'd0);
        check("rmiss_busy", {31'b0, busy_o}, 32'd0);
        fetch(32'h0000_0010, 32'hBBBB_0010, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
